// File: rtl/cascade_cache_reader_if.sv
// Cascade cache reader bus: cache read port (raddr/q) plus the downstream valid/ready word stream.
// The reader drives through the master modport; the cache and consumer side uses the slave modport.
interface cascade_cache_reader_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int WORD_SIZE  = 64
) ();

  logic [ADDR_WIDTH-1:0] raddr;
  logic [WORD_SIZE-1:0]  q;
  logic                  out_valid;
  logic                  out_ready;
  logic [WORD_SIZE-1:0]  out_data;
  logic                  out_last;

  modport master (
    output raddr,
    input  q,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_last
  );

  modport slave (
    input  raddr,
    output q,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_last
  );

endinterface

// File: rtl/cascade_cache_reader.sv
// Streams a burst of sequential cascade cache words downstream through a 2-entry skid FIFO.
// Optional backpressure counter stall_cnt is enabled by defining CCR_STALL_CNT_EN.
module cascade_cache_reader #(
  parameter int ADDR_WIDTH = 11,
  parameter int WORD_SIZE  = 64,
  parameter int WORDS      = 2048
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   count,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           stall_cnt,
  cascade_cache_reader_if.master bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] next_addr, last_raddr, issue_addr;
  logic [ADDR_WIDTH:0]   reads_left;
  logic                  in_flight, in_flight_last;
  logic [WORD_SIZE-1:0]  fifo_data [2];
  logic [1:0]            fifo_last;
  logic [1:0]            occ;
  logic                  rd_ptr, wr_ptr;
  logic                  accept, issue, issue_last, pop, head_last, room, done_nx;
  logic [2:0]            pending;

  assign accept    = (state == IDLE) && start && !done;
  assign pop       = (occ != 2'd0) && bus.out_ready;
  assign head_last = fifo_last[rd_ptr];
  // Credit check uses occupancy after this cycle's pop so a steady stream sustains 1 word/cycle.
  assign pending   = {1'b0, occ} + {2'b00, in_flight} - {2'b00, pop};
  assign room      = pending < 3'd2;

  always_comb begin
    state_nx   = state;
    issue      = 1'b0;
    issue_last = 1'b0;
    issue_addr = next_addr;
    done_nx    = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (count == '0) begin
            done_nx = 1'b1;
          end else begin
            issue      = 1'b1;
            issue_addr = base_addr;
            issue_last = (count == CNT_ONE);
            state_nx   = (count == CNT_ONE) ? DRAIN : ISSUE;
          end
        end
      end
      ISSUE: begin
        if (room) begin
          issue      = 1'b1;
          issue_last = (reads_left == CNT_ONE);
          if (reads_left == CNT_ONE) state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && head_last) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      done           <= 1'b0;
      next_addr      <= '0;
      last_raddr     <= '0;
      reads_left     <= '0;
      in_flight      <= 1'b0;
      in_flight_last <= 1'b0;
      fifo_last      <= '0;
      occ            <= '0;
      rd_ptr         <= 1'b0;
      wr_ptr         <= 1'b0;
    end else begin
      state          <= state_nx;
      done           <= done_nx;
      in_flight      <= issue;
      in_flight_last <= issue_last;
      if (issue) begin
        last_raddr <= issue_addr;
        next_addr  <= (issue_addr == LAST_ADDR) ? '0 : issue_addr + ADDR_ONE;
        reads_left <= ((state == IDLE) ? count : reads_left) - CNT_ONE;
      end
      if (in_flight) begin
        fifo_last[wr_ptr] <= in_flight_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      occ <= occ + {1'b0, in_flight} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (in_flight) fifo_data[wr_ptr] <= bus.q;
  end

  assign busy          = (state != IDLE);
  assign bus.raddr     = issue ? issue_addr : last_raddr;
  assign bus.out_valid = (occ != 2'd0);
  assign bus.out_data  = bus.out_valid ? fifo_data[rd_ptr] : '0;
  assign bus.out_last  = bus.out_valid & head_last;

`ifdef CCR_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (accept) begin
      stall_cnt <= '0;
    end else if (bus.out_valid && !bus.out_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`else
  assign stall_cnt = '0;
`endif

endmodule
